mem_access: RTL



---
 rtl/mem_access.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/mem_access.sv
// MEM pipeline stage: word-aligned, byte-strobed RAM access with stall/timeout and the MEM/WB register.
// Optional build macro MEM_ALIGN_CHECK_EN suppresses misaligned half/word accesses and flags them.
module mem_access #(
  parameter int TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        mem_read_flag_in,
  input  logic        mem_write_flag_in,
  input  logic        mem_sign_ext_flag_in,
  input  logic [3:0]  mem_sel_in,
  input  logic [31:0] mem_write_data_in,
  input  logic [31:0] result_in,
  input  logic        reg_write_en_in,
  input  logic [4:0]  reg_write_addr_in,
  input  logic [31:0] current_pc_addr_in,
  output logic        ram_en,
  output logic [3:0]  ram_write_en,
  output logic [31:0] ram_addr,
  output logic [31:0] ram_write_data,
  input  logic        ram_ready,
  input  logic [31:0] ram_read_data,
  output logic        stall_req,
  output logic        mem_read_flag_out,
  output logic        mem_write_flag_out,
  output logic        mem_sign_ext_flag_out,
  output logic [3:0]  mem_sel_out,
  output logic [31:0] result_out,
  output logic        reg_write_en_out,
  output logic [4:0]  reg_write_addr_out,
  output logic [31:0] current_pc_addr_out,
  output logic [31:0] ram_read_data_out,
  output logic        bus_error_out,
  output logic        addr_error_out
);

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

  state_t      state_reg, state_next;
  logic [7:0]  cnt_reg, cnt_next;
  logic        memop, misaligned;
  logic        en_c, stall_c, done, abort;
  logic [3:0]  strobe;

  assign memop = mem_read_flag_in | mem_write_flag_in;

`ifdef MEM_ALIGN_CHECK_EN
  assign misaligned = memop &
                      (((mem_sel_in == 4'b0011) & result_in[0]) |
                       ((mem_sel_in == 4'b1111) & (result_in[1:0] != 2'b00)));
`else
  assign misaligned = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= S_IDLE;
      cnt_reg   <= 8'd0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  // WAIT relies on EX/MEM being held by stall_req, so the live inputs are the held request.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    en_c       = 1'b0;
    stall_c    = 1'b0;
    done       = 1'b0;
    abort      = 1'b0;
    case (state_reg)
      S_IDLE: begin
        if (memop && !misaligned) begin
          en_c = 1'b1;
          if (ram_ready) begin
            done = 1'b1;
          end else begin
            stall_c    = 1'b1;
            state_next = S_WAIT;
            cnt_next   = 8'd1;
          end
        end
      end
      S_WAIT: begin
        if (cnt_reg >= TIMEOUT_CNT) begin
          abort      = 1'b1;
          state_next = S_IDLE;
          cnt_next   = 8'd0;
        end else begin
          en_c = 1'b1;
          if (ram_ready) begin
            done       = 1'b1;
            state_next = S_IDLE;
            cnt_next   = 8'd0;
          end else begin
            stall_c  = 1'b1;
            cnt_next = cnt_reg + 8'd1;
          end
        end
      end
      default: begin
        state_next = S_IDLE;
        cnt_next   = 8'd0;
      end
    endcase
  end

  // Reset kills the request in the very cycle it is sampled.
  assign ram_en    = en_c & ~rst;
  assign stall_req = stall_c & ~rst;
  assign ram_addr  = {result_in[31:2], 2'b00};

  always_comb begin
    strobe         = 4'b1111;
    ram_write_data = mem_write_data_in;
    case (mem_sel_in)
      4'b0001: begin
        strobe         = 4'b0001 << result_in[1:0];
        ram_write_data = {4{mem_write_data_in[7:0]}};
      end
      4'b0011: begin
        strobe         = 4'b0011 << result_in[1:0];
        ram_write_data = {2{mem_write_data_in[15:0]}};
      end
      default: ;
    endcase
  end

  assign ram_write_en = (ram_en & mem_write_flag_in) ? strobe : 4'b0000;

  always_ff @(posedge clk) begin
    if (rst || flush || stall_req) begin
      mem_read_flag_out     <= 1'b0;
      mem_write_flag_out    <= 1'b0;
      mem_sign_ext_flag_out <= 1'b0;
      mem_sel_out           <= 4'd0;
      result_out            <= 32'd0;
      reg_write_en_out      <= 1'b0;
      reg_write_addr_out    <= 5'd0;
      current_pc_addr_out   <= 32'd0;
      ram_read_data_out     <= 32'd0;
      bus_error_out         <= 1'b0;
      addr_error_out        <= 1'b0;
    end else begin
      mem_read_flag_out     <= mem_read_flag_in & ~misaligned;
      mem_write_flag_out    <= mem_write_flag_in & ~misaligned;
      mem_sign_ext_flag_out <= mem_sign_ext_flag_in;
      mem_sel_out           <= mem_sel_in;
      result_out            <= result_in;
      reg_write_en_out      <= reg_write_en_in & ~abort & ~misaligned;
      reg_write_addr_out    <= reg_write_addr_in;
      current_pc_addr_out   <= current_pc_addr_in;
      ram_read_data_out     <= done ? ram_read_data : 32'd0;
      bus_error_out         <= abort;
      addr_error_out        <= misaligned;
    end
  end

endmodule
